// File: rtl/riscv_defs.sv
`default_nettype none
// ============================================================================
// Package     : riscv_defs
// Description : Shared definitions for the CPU memory path: arbiter state
//               encodings, MEM access-size codes, owner codes and the
//               Stop/Go stall levels shared with the pipeline stall controller.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_defs;

   // Arbiter state encodings
   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_read  = 2'd1;
   localparam logic [1:0] c_st_write = 2'd2;
   localparam logic [1:0] c_st_done  = 2'd3;

   // MEM access-size codes (code 3 is treated as a word access)
   localparam logic [1:0] c_size_byte = 2'd0;
   localparam logic [1:0] c_size_half = 2'd1;
   localparam logic [1:0] c_size_word = 2'd2;

   // Transaction owner codes
   localparam logic c_owner_if  = 1'b0;
   localparam logic c_owner_mem = 1'b1;

   // Stall levels driven to the stall controller
   localparam logic Stop = 1'b1;
   localparam logic Go   = 1'b0;

   // Number of byte cycles for a MEM access size code
   function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         c_size_byte: n = 3'd1;
         c_size_half: n = 3'd2;
         c_size_word: n = 3'd4;
         default:     n = 3'd4;
      endcase
      return n;
   endfunction

endpackage : riscv_defs
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single byte-wide RAM port between instruction
//               fetch (IF, always 4-byte reads) and the MEM stage (1/2/4-byte
//               reads and writes). Word requests are split into byte cycles
//               and assembled/disassembled little-endian. MEM has priority.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               rdy                - chip ready; low freezes all state
//               if_req/if_addr     - IF fetch request and byte address
//               if_flush           - abandon an in-flight IF read
//               if_done/if_data    - IF completion pulse and instruction
//               mem_req/mem_we     - MEM request, 1 = write
//               mem_size           - 0 = 1B, 1 = 2B, 2/3 = 4B
//               mem_addr/mem_wdata - MEM byte address and store data
//               mem_done/mem_rdata - MEM completion pulse and load data
//               ram_din            - RAM read data (one cycle after address)
//               ram_dout/ram_a     - RAM write data and address
//               ram_wr             - RAM write enable
//               if_stall/mem_stall - stall levels for the stall controller
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import riscv_defs::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_done,
   output logic [31:0]       if_data,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_size,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_done,
   output logic [31:0]       mem_rdata,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr,
   output logic              if_stall,
   output logic              mem_stall
);

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;
   logic              r_owner;
   logic [2:0]        r_cnt;
   logic [2:0]        r_len;
   logic [ADDR_W-1:0] r_base;
   logic [31:0]       r_wdata;
   logic [31:0]       r_asm;

   logic              w_grant_mem;
   logic              w_grant_if;
   logic              w_if_flushed;
   logic [1:0]        w_cap_sel;

   // IF can only be granted when MEM is not asking in the same cycle
   assign w_grant_mem  = (r_state == c_st_idle) && mem_req;
   assign w_grant_if   = (r_state == c_st_idle) && !mem_req && if_req && !if_flush;
   assign w_if_flushed = (r_state == c_st_read) && (r_owner == c_owner_if) && if_flush;

   // Byte lane being captured: data returned for address base+c-1.
   // At c = 4 the low two bits wrap to 0, giving lane 3 as required.
   assign w_cap_sel = r_cnt[1:0] - 2'd1;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else if (rdy) begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_grant_mem) begin
               w_next_state = mem_we ? c_st_write : c_st_read;
            end else if (w_grant_if) begin
               w_next_state = c_st_read;
            end
         end
         c_st_read: begin
            // The extra count step at c = n collects the last returned byte
            if (w_if_flushed) begin
               w_next_state = c_st_idle;
            end else if (r_cnt == r_len) begin
               w_next_state = c_st_done;
            end
         end
         c_st_write: begin
            if (r_cnt == (r_len - 3'd1)) begin
               w_next_state = c_st_done;
            end
         end
         c_st_done: begin
            w_next_state = c_st_idle;
         end
         default: begin
            w_next_state = c_st_idle;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Transaction datapath: operand latch, byte counter, read assembly
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner <= c_owner_if;
         r_cnt   <= 3'd0;
         r_len   <= 3'd0;
         r_base  <= '0;
         r_wdata <= 32'd0;
         r_asm   <= 32'd0;
      end else if (rdy) begin
         case (r_state)
            c_st_idle: begin
               r_cnt <= 3'd0;
               // Cleared so narrow MEM loads come back zero-extended
               r_asm <= 32'd0;
               if (w_grant_mem) begin
                  r_owner <= c_owner_mem;
                  r_len   <= size_to_bytes(mem_size);
                  r_base  <= mem_addr;
                  r_wdata <= mem_wdata;
               end else if (w_grant_if) begin
                  r_owner <= c_owner_if;
                  r_len   <= 3'd4;
                  r_base  <= if_addr;
               end
            end
            c_st_read: begin
               if (r_cnt != 3'd0) begin
                  r_asm[{w_cap_sel, 3'b000} +: 8] <= ram_din;
               end
               r_cnt <= (w_next_state == c_st_read) ? r_cnt + 3'd1 : 3'd0;
            end
            c_st_write: begin
               r_cnt <= (w_next_state == c_st_write) ? r_cnt + 3'd1 : 3'd0;
            end
            default: begin
               r_cnt <= 3'd0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------------
   always_comb begin
      ram_a     = '0;
      ram_dout  = 8'd0;
      ram_wr    = 1'b0;
      if_done   = 1'b0;
      mem_done  = 1'b0;
      if_data   = 32'd0;
      mem_rdata = 32'd0;
      case (r_state)
         c_st_read: begin
            if (r_cnt < r_len) begin
               ram_a = r_base + ADDR_W'(r_cnt);
            end
         end
         c_st_write: begin
            // A frozen cycle must not repeat the write
            ram_wr   = rdy;
            ram_a    = r_base + ADDR_W'(r_cnt);
            ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
         end
         c_st_done: begin
            // Done is gated by rdy so it marks the single cycle the
            // transaction actually retires
            if (r_owner == c_owner_mem) begin
               mem_done  = rdy;
               mem_rdata = r_asm;
            end else begin
               if_done   = rdy;
               if_data   = r_asm;
            end
         end
         default: begin
         end
      endcase
   end

   assign if_stall  = (if_req  && !if_done)  ? Stop : Go;
   assign mem_stall = (mem_req && !mem_done) ? Stop : Go;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Directed stimulus pushes
//               expected completions into a scoreboard; a monitor pops and
//               compares on every done pulse. A byte RAM model answers reads
//               one cycle after the address and applies writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              rdy;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_done;
   logic [31:0]       if_data;
   logic              mem_req;
   logic              mem_we;
   logic [1:0]        mem_size;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_done;
   logic [31:0]       mem_rdata;
   logic [7:0]        ram_din;
   logic [7:0]        ram_dout;
   logic [ADDR_W-1:0] ram_a;
   logic              ram_wr;
   logic              if_stall;
   logic              mem_stall;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_done   (if_done),
      .if_data   (if_data),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_size  (mem_size),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_done  (mem_done),
      .mem_rdata (mem_rdata),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .ram_a     (ram_a),
      .ram_wr    (ram_wr),
      .if_stall  (if_stall),
      .mem_stall (mem_stall)
   );

   // Cycle index: value seen at a falling edge = number of rising edges so far
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous byte RAM model
   logic [7:0] ram [0:16383];
   always @(posedge clk) begin
      ram_din <= ram[ram_a[13:0]];
      if (ram_wr) ram[ram_a[13:0]] <= ram_dout;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      bit          is_mem;
      bit          chk_data;
      logic [31:0] data;
      int          at;
   } exp_t;

   exp_t sb[$];

   task automatic push_exp(input bit is_mem, input bit chk_data, input logic [31:0] data, input int at);
      exp_t e;
      e.is_mem   = is_mem;
      e.chk_data = chk_data;
      e.data     = data;
      e.at       = at;
      sb.push_back(e);
   endtask

   // Monitor: every done pulse must match the oldest expected completion
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (if_done || mem_done)) begin
         if (sb.size() == 0) begin
            check("unexpected_done", {62'd0, if_done, mem_done}, 64'd0);
         end else begin
            e = sb.pop_front();
            check("done_owner", {62'd0, if_done, mem_done}, e.is_mem ? 64'd1 : 64'd2);
            if (e.chk_data) check("done_data", e.is_mem ? mem_rdata : if_data, e.data);
            check("done_cycle", cyc, e.at);
         end
      end
   end

   // Wait (bounded) for the next done pulse; returns at that falling edge
   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (if_done || mem_done) seen = 1'b1;
      end
      check({name, "_done_seen"}, {63'd0, seen}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0;
      for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
      ram[14'h1000] = 8'h13; ram[14'h1001] = 8'h00;
      ram[14'h1002] = 8'h00; ram[14'h1003] = 8'h93;
      ram[14'h2003] = 8'h5A;
      ram[14'h3000] = 8'h37; ram[14'h3001] = 8'h12;

      rst = 1'b1; rdy = 1'b1;
      if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = '0; mem_wdata = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("reset_ctrl", {53'd0, if_done, mem_done, ram_wr, ram_dout}, 64'd0);
      check("reset_ram_a", ram_a, 64'd0);
      check("reset_data", {if_data, mem_rdata}, 64'd0);
      check("reset_stall", {62'd0, if_stall, mem_stall}, 64'd0);

      // IF 4-byte read at 0x1000
      t0 = cyc;
      if_req = 1'b1; if_addr = 32'h1000;
      push_exp(1'b0, 1'b1, 32'h93000013, t0 + 6);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check("t1_ram_a", ram_a, 64'(32'h1000 + i - 1));
      end
      wait_done("t1");
      if_req = 1'b0;
      @(negedge clk);

      // MEM 1-byte read and IF request collide: MEM first
      t0 = cyc;
      mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h2003;
      if_req = 1'b1; if_addr = 32'h1000;
      push_exp(1'b1, 1'b1, 32'h0000005A, t0 + 3);
      push_exp(1'b0, 1'b1, 32'h93000013, t0 + 10);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("t2_if_stall", {63'd0, if_stall}, 64'd1);
      end
      mem_req = 1'b0;
      @(negedge clk);
      check("t2_if_stall_idle", {63'd0, if_stall}, 64'd1);
      check("t2_idle_ram_a", ram_a, 64'd0);
      @(negedge clk);
      check("t2_if_granted", ram_a, 64'h1000);
      wait_done("t2");
      check("t2_if_stall_done", {63'd0, if_stall}, 64'd0);
      if_req = 1'b0;
      @(negedge clk);

      // MEM 2-byte write of 0xDEADBEEF to 0x10
      t0 = cyc;
      mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd1; mem_addr = 32'h10; mem_wdata = 32'hDEADBEEF;
      push_exp(1'b1, 1'b0, 32'h0, t0 + 3);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("t3_ram_wr", {63'd0, ram_wr}, (i <= 2) ? 64'd1 : 64'd0);
         if (i <= 2) begin
            check("t3_ram_a", ram_a, 64'(32'h10 + i - 1));
            check("t3_ram_dout", {56'd0, ram_dout}, (i == 1) ? 64'hEF : 64'hBE);
         end
      end
      mem_req = 1'b0; mem_we = 1'b0;
      @(negedge clk);
      check("t3_ram10", {56'd0, ram[14'h10]}, 64'hEF);
      check("t3_ram11", {56'd0, ram[14'h11]}, 64'hBE);
      check("t3_ram12", {56'd0, ram[14'h12]}, 64'h00);

      // IF read flushed in cycle 3, redirected fetch at 0x3000 in cycle 4
      t0 = cyc;
      if_req = 1'b1; if_addr = 32'h1000;
      repeat (3) @(negedge clk);
      if_flush = 1'b1; if_addr = 32'h3000;
      @(negedge clk);
      if_flush = 1'b0;
      check("t4_idle_ram_a", ram_a, 64'd0);
      push_exp(1'b0, 1'b1, 32'h00001237, t0 + 10);
      @(negedge clk);
      check("t4_redirect_ram_a", ram_a, 64'h3000);
      wait_done("t4");
      if_req = 1'b0;
      @(negedge clk);

      // Reset in cycle 2 of a MEM 4-byte write
      mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h20; mem_wdata = 32'hDEADBEEF;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         check("t5_ram_wr", {63'd0, ram_wr}, 64'd1);
      end
      rst = 1'b1;
      @(negedge clk);
      check("t5_ctrl", {53'd0, if_done, mem_done, ram_wr, ram_dout}, 64'd0);
      check("t5_ram_a", ram_a, 64'd0);
      check("t5_data", {if_data, mem_rdata}, 64'd0);
      rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_ram_bytes", {32'd0, ram[14'h23], ram[14'h22], ram[14'h21], ram[14'h20]}, 64'h0000BEEF);

      // IF read with rdy low for 2 cycles
      t0 = cyc;
      if_req = 1'b1; if_addr = 32'h1000;
      push_exp(1'b0, 1'b1, 32'h93000013, t0 + 8);
      @(negedge clk);
      rdy = 1'b0;
      @(negedge clk);
      check("t6_hold_ram_a", ram_a, 64'h1000);
      @(negedge clk);
      rdy = 1'b1;
      check("t6_hold_ram_a2", ram_a, 64'h1000);
      wait_done("t6");
      if_req = 1'b0;

      repeat (5) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mem_arbiter
`default_nettype wire
